bram_sd_sync: RTL and testbench
===============================

Name: bram_sd_sync

Overview:
- Parametrised successor to the single-slot backup-RAM save/load sequencer in the console top levels.
- Moves a backup-RAM image of 2^SECTOR_BITS sectors between the core and the HPS SD sector interface, into one of 2^SLOT_BITS slots.
- New behaviour: dirty tracking, idle-triggered autosave, ack timeout, and a clean abort when the save file is unmounted.
- Sits between hps_io (sd_* signals) and the core's backup RAM. `loading` holds the core in reset while a load is in progress.

Parameters:
- SECTOR_BITS, 6: log2 of sectors per slot. Sector index width.
- SLOT_BITS, 2: log2 of slot count.
- LBA_W, 32: width of sd_lba.
- IDLE_CYC, 24'd10_000_000: clk_sys cycles with no backup-RAM write before autosave fires. Must be ≥ 2.
- ACK_TO, 24'd50_000_000: cycles allowed between sd_rd/sd_wr assertion and the sd_ack rise.

Ports:
- clk_sys, in, 1: system clock.
- reset_n, in, 1: synchronous reset, active-low.
- enable, in, 1: save file mounted and writable.
- load_req, in, 1: level request. Rising edge starts a load.
- save_req, in, 1: level request. Rising edge starts a save.
- slot, in, SLOT_BITS: target slot, captured at start.
- autosave_en, in, 1: allows idle-triggered saves.
- mem_wr, in, 1: core wrote backup RAM this cycle.
- sd_ack, in, 1: HPS sector handshake acknowledge.
- sd_lba, out, LBA_W: sector address.
- sd_rd, out, 1: sector read request.
- sd_wr, out, 1: sector write request.
- busy, out, 1: transfer in progress.
- loading, out, 1: load in progress. Drives core reset.
- dirty, out, 1: backup RAM differs from the slot image.
- done, out, 1: one-cycle pulse on successful completion.
- err, out, 1: one-cycle pulse on timeout or abort.

Behaviour:
- Reset (reset_n=0 at a clock edge): all outputs 0, FSM to IDLE, counters 0, edge-detect registers 0.
- Edge detect: rise = req & ~req_q, where req_q registers (req & enable). Requests are ignored unless in IDLE with enable=1.
- Load and save rising in the same cycle: load wins, save is dropped.
- Autosave trigger: in IDLE with dirty & autosave_en & enable, idle_cnt increments each cycle and clears on any mem_wr. When idle_cnt reaches IDLE_CYC-1, a save of the current `slot` starts. idle_cnt is held at 0 outside that condition.
- sd_lba = zero-extended {slot_q, sector}.
- FSM states: IDLE, REQ, XFER, ABORT.
- IDLE → REQ on a start event:
  - capture slot_q; sector = 0; is_load set for a load.
  - on the next edge: sd_rd = is_load, sd_wr = ~is_load, busy = 1, loading = is_load, to_cnt = 0.
  - a save clears dirty in the same cycle.
- REQ:
  - to_cnt increments each cycle.
  - sd_ack rise (sd_ack & ~ack_q): sd_rd = sd_wr = 0, go to XFER.
  - to_cnt == ACK_TO-1: drop sd_rd/sd_wr, pulse err, go to IDLE. A save that times out sets dirty again.
- XFER, on sd_ack fall:
  - if sector is all ones: go to IDLE, busy = loading = 0, pulse done. A completed load clears dirty.
  - otherwise: sector += 1, reassert the same request, to_cnt = 0, go to REQ.
- Sector counter wraps only by the completion check. It never exceeds 2^SECTOR_BITS-1.
- enable falling while busy:
  - sd_rd/sd_wr drop on the next edge.
  - if sd_ack=1, go to ABORT and wait for sd_ack=0; then IDLE.
  - err pulses on entry to IDLE; busy/loading clear; a save sets dirty again.
- mem_wr sets dirty in any state, including during a save, so the next autosave catches it. The set has priority over the save-start clear in the same cycle.
- Latency: a request edge sampled at edge N gives sd_rd/sd_wr high after edge N+1.
- Each sector: exactly one sd_rd/sd_wr assertion, and it stays high until the cycle after the ack rise.

Test Plan:
- Save slot 2, SECTOR_BITS=6; model acks 5 cycles after each request and holds ack 3 cycles → sd_lba 0x80..0xBF in order, 64 sd_wr assertions, done pulse once, busy low afterwards, dirty=0.
- Load slot 0 with load_req and save_req rising together → only sd_rd toggles; loading=1 for the whole transfer; sd_lba 0x00..0x3F; dirty=0 at the end.
- IDLE_CYC=100, autosave_en=1, one mem_wr pulse, then quiet → save starts exactly 100 cycles after the pulse. A second mem_wr at cycle 50 restarts the count.
- ACK_TO=20, sd_ack never rises → sd_wr high for 20 cycles then drops, err pulse, dirty=1, FSM back in IDLE, next request accepted.
- enable drops during sector 10 while sd_ack=1 → sd_wr low next cycle; busy stays until ack falls; then err pulse and no further sd_lba change.
- reset_n low mid-transfer (sector 5) → on the next edge all outputs 0, FSM in IDLE, no done/err pulse.

Source files
------------

// File: rtl/bram_sd_sync_if.sv
// HPS SD sector handshake: the sequencer drives address and read/write strobes,
// the HPS side answers with sd_ack.
interface bram_sd_sync_if #(
  parameter int LBA_W = 32
);
  logic [LBA_W-1:0] sd_lba;
  logic             sd_rd;
  logic             sd_wr;
  logic             sd_ack;

  modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
  modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);
endinterface

// File: rtl/bram_sd_sync.sv
// Backup-RAM save/load sequencer: streams one slot image sector by sector over the
// HPS SD interface, with dirty tracking, idle autosave, ack timeout and clean abort.
module bram_sd_sync #(
  parameter int          SECTOR_BITS = 6,
  parameter int          SLOT_BITS   = 2,
  parameter int          LBA_W       = 32,
  parameter logic [23:0] IDLE_CYC    = 24'd10_000_000,
  parameter logic [23:0] ACK_TO      = 24'd50_000_000
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 load_req,
  input  logic                 save_req,
  input  logic [SLOT_BITS-1:0] slot,
  input  logic                 autosave_en,
  input  logic                 mem_wr,
  bram_sd_sync_if.master       sd,
  output logic                 busy,
  output logic                 loading,
  output logic                 dirty,
  output logic                 done,
  output logic                 err
);

  localparam int PAD_W = LBA_W - SLOT_BITS - SECTOR_BITS;

  typedef enum logic [1:0] {IDLE, REQ, XFER, ABORT} state_t;

  state_t                 state_q, state_d;
  logic [SLOT_BITS-1:0]   slot_q, slot_d;
  logic [SECTOR_BITS-1:0] sector_q, sector_d;
  logic                   is_load_q, is_load_d;
  logic                   issue_q, issue_d;
  logic [23:0]            to_cnt_q, to_cnt_d;
  logic [23:0]            idle_cnt_q, idle_cnt_d;
  logic                   load_req_q, load_req_d;
  logic                   save_req_q, save_req_d;
  logic                   ack_q, ack_d;
  logic                   sd_rd_q, sd_rd_d;
  logic                   sd_wr_q, sd_wr_d;
  logic                   busy_q, busy_d;
  logic                   loading_q, loading_d;
  logic                   dirty_q, dirty_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic in_idle, load_rise, save_rise, start_load, start_save;
  logic auto_arm, auto_fire, start, ack_rise, ack_fall, timeout, last_sector;
  logic fail;

  assign in_idle     = (state_q == IDLE);
  assign load_rise   = load_req & ~load_req_q;
  assign save_rise   = save_req & ~save_req_q;
  assign start_load  = in_idle & enable & load_rise;
  // Simultaneous load/save: load wins and the save edge is consumed.
  assign start_save  = in_idle & enable & save_rise & ~load_rise;
  assign auto_arm    = in_idle & enable & autosave_en & dirty_q;
  assign auto_fire   = auto_arm & ~mem_wr & (idle_cnt_q == IDLE_CYC - 24'd1);
  assign start       = start_load | start_save | auto_fire;
  assign ack_rise    = sd.sd_ack & ~ack_q;
  assign ack_fall    = ~sd.sd_ack & ack_q;
  assign timeout     = (to_cnt_q == ACK_TO - 24'd1);
  assign last_sector = &sector_q;

  assign load_req_d = load_req & enable;
  assign save_req_d = save_req & enable;
  assign ack_d      = sd.sd_ack;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      sector_q   <= '0;
      is_load_q  <= 1'b0;
      issue_q    <= 1'b0;
      to_cnt_q   <= '0;
      idle_cnt_q <= '0;
      load_req_q <= 1'b0;
      save_req_q <= 1'b0;
      ack_q      <= 1'b0;
      sd_rd_q    <= 1'b0;
      sd_wr_q    <= 1'b0;
      busy_q     <= 1'b0;
      loading_q  <= 1'b0;
      dirty_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      sector_q   <= sector_d;
      is_load_q  <= is_load_d;
      issue_q    <= issue_d;
      to_cnt_q   <= to_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      load_req_q <= load_req_d;
      save_req_q <= save_req_d;
      ack_q      <= ack_d;
      sd_rd_q    <= sd_rd_d;
      sd_wr_q    <= sd_wr_d;
      busy_q     <= busy_d;
      loading_q  <= loading_d;
      dirty_q    <= dirty_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = REQ;
      REQ: begin
        if (!enable)       state_d = sd.sd_ack ? ABORT : IDLE;
        else if (issue_q)  state_d = REQ;
        else if (ack_rise) state_d = XFER;
        else if (timeout)  state_d = IDLE;
      end
      XFER: begin
        if (!enable)       state_d = sd.sd_ack ? ABORT : IDLE;
        else if (ack_fall) state_d = last_sector ? IDLE : REQ;
      end
      ABORT: if (!sd.sd_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    slot_d     = slot_q;
    sector_d   = sector_q;
    is_load_d  = is_load_q;
    issue_d    = 1'b0;
    to_cnt_d   = to_cnt_q;
    idle_cnt_d = '0;
    sd_rd_d    = sd_rd_q;
    sd_wr_d    = sd_wr_q;
    busy_d     = busy_q;
    loading_d  = loading_q;
    dirty_d    = dirty_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fail       = 1'b0;
    case (state_q)
      IDLE: begin
        if (auto_arm) idle_cnt_d = mem_wr ? '0 : idle_cnt_q + 24'd1;
        if (start) begin
          slot_d     = slot;
          sector_d   = '0;
          is_load_d  = start_load;
          issue_d    = 1'b1;
          idle_cnt_d = '0;
        end
      end
      REQ: begin
        if (!enable) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          fail    = ~sd.sd_ack;
        end else if (issue_q) begin
          // First strobe of a transfer goes out one cycle after the start edge.
          sd_rd_d   = is_load_q;
          sd_wr_d   = ~is_load_q;
          busy_d    = 1'b1;
          loading_d = is_load_q;
          to_cnt_d  = '0;
          if (!is_load_q) dirty_d = 1'b0;
        end else if (ack_rise) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
        end else if (timeout) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          fail    = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 24'd1;
        end
      end
      XFER: begin
        if (!enable) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          fail    = ~sd.sd_ack;
        end else if (ack_fall) begin
          if (last_sector) begin
            busy_d    = 1'b0;
            loading_d = 1'b0;
            done_d    = 1'b1;
            if (is_load_q) dirty_d = 1'b0;
          end else begin
            sector_d = sector_q + SECTOR_BITS'(1);
            sd_rd_d  = is_load_q;
            sd_wr_d  = ~is_load_q;
            to_cnt_d = '0;
          end
        end
      end
      ABORT: fail = ~sd.sd_ack;
      default: ;
    endcase
    // An unfinished save leaves the slot image stale, so the RAM is dirty again.
    if (fail) begin
      busy_d    = 1'b0;
      loading_d = 1'b0;
      err_d     = 1'b1;
      if (!is_load_q) dirty_d = 1'b1;
    end
    if (mem_wr) dirty_d = 1'b1;
  end

  assign sd.sd_lba = {{PAD_W{1'b0}}, slot_q, sector_q};
  assign sd.sd_rd  = sd_rd_q;
  assign sd.sd_wr  = sd_wr_q;
  assign busy      = busy_q;
  assign loading   = loading_q;
  assign dirty     = dirty_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bram_sd_sync.sv
// Directed/randomised bench for bram_sd_sync with a behavioural HPS responder
// and an arithmetic model of the expected sector address sequence.
module tb_bram_sd_sync;
  localparam int SECB = 6;
  localparam int SLB  = 2;
  localparam int LW   = 32;
  localparam int NSEC = 1 << SECB;
  localparam int IDLE = 100;
  localparam int ATO  = 20;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic           reset_n, enable, load_req, save_req, autosave_en, mem_wr;
  logic [SLB-1:0] slot;
  logic           busy, loading, dirty, done, err;

  bram_sd_sync_if #(.LBA_W(LW)) sd_if ();

  bram_sd_sync #(
    .SECTOR_BITS(SECB), .SLOT_BITS(SLB), .LBA_W(LW),
    .IDLE_CYC(24'd100), .ACK_TO(24'd20)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable),
    .load_req(load_req), .save_req(save_req), .slot(slot),
    .autosave_en(autosave_en), .mem_wr(mem_wr), .sd(sd_if),
    .busy(busy), .loading(loading), .dirty(dirty), .done(done), .err(err)
  );

  // HPS responder: ack some cycles after a strobe, hold it for a few cycles.
  int hps_on   = 0;
  int ack_dly  = 5;
  int ack_hold = 3;
  int acnt     = 0;
  always @(negedge clk_sys) begin
    if (hps_on == 0) begin
      sd_if.sd_ack = 1'b0;
      acnt = 0;
    end else if (!sd_if.sd_ack) begin
      if (sd_if.sd_rd | sd_if.sd_wr) begin
        acnt++;
        if (acnt >= ack_dly) begin sd_if.sd_ack = 1'b1; acnt = 0; end
      end else acnt = 0;
    end else begin
      acnt++;
      if (acnt >= ack_hold) begin sd_if.sd_ack = 1'b0; acnt = 0; end
    end
  end

  logic [LW-1:0] wr_lba_q[$];
  logic [LW-1:0] rd_lba_q[$];
  int   done_cnt = 0, err_cnt = 0;
  logic wr_prev = 1'b0, rd_prev = 1'b0;
  always @(negedge clk_sys) begin
    if (sd_if.sd_wr === 1'b1 && !wr_prev) wr_lba_q.push_back(sd_if.sd_lba);
    if (sd_if.sd_rd === 1'b1 && !rd_prev) rd_lba_q.push_back(sd_if.sd_lba);
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
    wr_prev = (sd_if.sd_wr === 1'b1);
    rd_prev = (sd_if.sd_rd === 1'b1);
  end

  int n_total = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_mem_wr();
    mem_wr = 1'b1;
    tick();
    mem_wr = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin tick(); k++; end
    chk(tag, done, 1'b1);
  endtask

  // Expected image address: slot selects a block of NSEC consecutive sectors.
  function automatic int lba_bad(input bit use_rd, input int base, input int slotv);
    int bad = 0;
    logic [LW-1:0] e, o;
    for (int i = 0; i < NSEC; i++) begin
      e = LW'(slotv * NSEC + i);
      if (use_rd) o = (base + i < rd_lba_q.size()) ? rd_lba_q[base+i] : '1;
      else        o = (base + i < wr_lba_q.size()) ? wr_lba_q[base+i] : '1;
      if (o !== e) bad++;
    end
    return bad;
  endfunction

  initial begin
    int wb, rb, d0, e0, bad, k, rslot;
    reset_n = 1'b0; enable = 1'b0; load_req = 1'b0; save_req = 1'b0;
    slot = '0; autosave_en = 1'b0; mem_wr = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_wr", sd_if.sd_wr, 0);
    chk("rst_rd", sd_if.sd_rd, 0);
    chk("rst_lba", sd_if.sd_lba, 0);
    chk("rst_dirty", dirty, 0);
    chk("rst_done_err", {done, err, loading}, 0);

    // Save slot 2
    reset_n = 1'b1; enable = 1'b1; hps_on = 1;
    ack_dly = 5; ack_hold = 3;
    tick();
    pulse_mem_wr();
    chk("dirty_set", dirty, 1);
    wb = wr_lba_q.size(); rb = rd_lba_q.size(); d0 = done_cnt;
    slot = 2'd2; save_req = 1'b1;
    tick();
    chk("save_lat_n1", sd_if.sd_wr, 0);
    tick();
    chk("save_lat_n2", sd_if.sd_wr, 1);
    chk("save_busy", busy, 1);
    chk("save_first_lba", sd_if.sd_lba, 32'h80);
    chk("save_dirty_clr", dirty, 0);
    wait_done("save_done", 3000);
    chk("save_busy_end", busy, 0);
    save_req = 1'b0;
    tick();
    chk("save_nwr", wr_lba_q.size() - wb, NSEC);
    chk("save_seq", lba_bad(1'b0, wb, 2), 0);
    chk("save_nrd", rd_lba_q.size() - rb, 0);
    chk("save_done_once", done_cnt - d0, 1);
    chk("save_dirty_end", dirty, 0);

    // Load slot 0 with load and save rising together
    pulse_mem_wr();
    wb = wr_lba_q.size(); rb = rd_lba_q.size();
    slot = 2'd0; load_req = 1'b1; save_req = 1'b1;
    tick();
    tick();
    chk("load_rd", sd_if.sd_rd, 1);
    chk("load_wr", sd_if.sd_wr, 0);
    chk("load_loading", loading, 1);
    bad = 0; k = 0;
    while (done !== 1'b1 && k < 3000) begin
      tick(); k++;
      if (done !== 1'b1 && loading !== 1'b1) bad++;
    end
    chk("load_done", done, 1);
    chk("load_loading_held", bad, 0);
    repeat (3) tick();
    chk("load_nrd", rd_lba_q.size() - rb, NSEC);
    chk("load_seq", lba_bad(1'b1, rb, 0), 0);
    chk("load_nwr", wr_lba_q.size() - wb, 0);
    chk("load_dirty_end", dirty, 0);
    chk("load_idle", {busy, loading}, 0);
    load_req = 1'b0; save_req = 1'b0;
    tick();

    // Idle autosave with count restart
    slot = 2'd1; autosave_en = 1'b1;
    pulse_mem_wr();
    repeat (IDLE / 2 - 1) tick();
    pulse_mem_wr();
    bad = 0;
    for (int j = 1; j <= IDLE; j++) begin
      tick();
      if (sd_if.sd_wr !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("auto_early", bad, 0);
    tick();
    chk("auto_wr", sd_if.sd_wr, 1);
    chk("auto_lba", sd_if.sd_lba, 32'h40);
    autosave_en = 1'b0;
    wait_done("auto_done", 3000);
    tick();
    chk("auto_dirty_end", dirty, 0);

    // Ack timeout on slot 3
    hps_on = 0;
    slot = 2'd3; save_req = 1'b1;
    tick();
    tick();
    chk("to_wr_on", sd_if.sd_wr, 1);
    bad = 0;
    for (int j = 1; j < ATO; j++) begin
      tick();
      if (sd_if.sd_wr !== 1'b1) bad++;
    end
    chk("to_wr_held", bad, 0);
    tick();
    chk("to_wr_off", sd_if.sd_wr, 0);
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    chk("to_dirty", dirty, 1);
    hps_on = 1; save_req = 1'b0;
    tick();
    save_req = 1'b1;
    tick();
    tick();
    chk("to_next_wr", sd_if.sd_wr, 1);
    chk("to_next_lba", sd_if.sd_lba, 32'hC0);
    wait_done("to_next_done", 3000);
    save_req = 1'b0;
    tick();

    // Random ack timing, random slot, then unmount during sector 10
    ack_dly = $urandom_range(1, 6); ack_hold = $urandom_range(2, 4);
    rslot = $urandom_range(0, 3);
    slot = SLB'(rslot); wb = wr_lba_q.size(); d0 = done_cnt;
    save_req = 1'b1;
    k = 0;
    while (!(sd_if.sd_lba == LW'(rslot * NSEC + 10) && sd_if.sd_ack === 1'b1) && k < 2000) begin
      tick(); k++;
    end
    chk("ab_reach_sec10", k < 2000, 1);
    chk("ab_seq_prefix", wr_lba_q.size() - wb, 11);
    enable = 1'b0; save_req = 1'b0; e0 = err_cnt;
    tick();
    chk("ab_wr_low", sd_if.sd_wr, 0);
    chk("ab_busy_hold", busy, 1);
    k = 0;
    while (busy !== 1'b0 && k < 50) begin tick(); k++; end
    chk("ab_busy_clr", busy, 0);
    chk("ab_err", err, 1);
    repeat (5) tick();
    chk("ab_lba_frozen", sd_if.sd_lba, LW'(rslot * NSEC + 10));
    chk("ab_err_once", err_cnt - e0, 1);
    chk("ab_no_done", done_cnt - d0, 0);
    chk("ab_dirty", dirty, 1);
    chk("ab_strobes", {sd_if.sd_wr, sd_if.sd_rd}, 0);
    enable = 1'b1; ack_dly = 5; ack_hold = 3;
    tick();

    // Reset in the middle of sector 5
    slot = 2'd2; save_req = 1'b1;
    k = 0;
    while (!(sd_if.sd_lba == 32'h85 && sd_if.sd_wr === 1'b1) && k < 2000) begin
      tick(); k++;
    end
    chk("rs_reach_sec5", k < 2000, 1);
    reset_n = 1'b0; save_req = 1'b0; d0 = done_cnt; e0 = err_cnt;
    tick();
    chk("rs_outs", {busy, loading, dirty, done, err, sd_if.sd_wr, sd_if.sd_rd}, 0);
    chk("rs_lba", sd_if.sd_lba, 0);
    reset_n = 1'b1;
    repeat (4) tick();
    chk("rs_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
    chk("rs_idle", {busy, sd_if.sd_wr}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
